// File: rtl/fsm_seq_gen.sv
// Moore serial pattern transmitter: latches a pattern on start&ready, shifts it out MSB-first,
// optionally repeats with an idle gap. Optional parity bit per frame under `SEQ_PARITY_EN.
module fsm_seq_gen #(
  parameter int PAT_W = 5,
  parameter int REP_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [REP_W-1:0] rep_in,
  input  logic [GAP_W-1:0] gap_in,
  input  logic             abort,
  output logic             data,
  output logic             data_vld,
  output logic             ready,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | waiting for start, ready=1
  // SHIFT | emitting pattern bits MSB-first
  // GAP   | idle cycles between frames
  // PAR   | even-parity bit after each frame (SEQ_PARITY_EN only)
  // DONE  | one-cycle done pulse
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_GAP   = 3'd2,
`ifdef SEQ_PARITY_EN
    S_PAR   = 3'd3,
`endif
    S_DONE  = 3'd4
  } state_t;

  localparam int BIT_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

  state_t           r_state, w_nstate;
  logic             r_data, w_data;
  logic             r_vld, w_vld;
  logic [PAT_W-1:0] r_pat, w_pat;
  logic [PAT_W-1:0] r_sh, w_sh;
  logic [BIT_W-1:0] r_bit_cnt, w_bit_cnt;
  logic [REP_W-1:0] r_rep_cnt, w_rep_cnt;
  logic [GAP_W-1:0] r_gap, w_gap;
  logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt;
  logic             w_load;
  logic             w_frame_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_data    <= 1'b0;
      r_vld     <= 1'b0;
      r_pat     <= '0;
      r_sh      <= '0;
      r_bit_cnt <= '0;
      r_rep_cnt <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_nstate;
      r_data    <= w_data;
      r_vld     <= w_vld;
      r_pat     <= w_pat;
      r_sh      <= w_sh;
      r_bit_cnt <= w_bit_cnt;
      r_rep_cnt <= w_rep_cnt;
      r_gap     <= w_gap;
      r_gap_cnt <= w_gap_cnt;
    end
  end

  always_comb begin
    w_nstate    = r_state;
    w_data      = 1'b0;
    w_vld       = 1'b0;
    w_pat       = r_pat;
    w_sh        = r_sh;
    w_bit_cnt   = r_bit_cnt;
    w_rep_cnt   = r_rep_cnt;
    w_gap       = r_gap;
    w_gap_cnt   = r_gap_cnt;
    w_load      = 1'b0;
    w_frame_end = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_pat     = pat_in;
          w_rep_cnt = rep_in;
          w_gap     = gap_in;
          w_load    = 1'b1;
          w_nstate  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_bit_cnt == LAST_BIT) begin
`ifdef SEQ_PARITY_EN
          w_nstate = S_PAR;
          w_data   = ^r_pat;
          w_vld    = 1'b1;
`else
          w_frame_end = 1'b1;
`endif
        end else begin
          w_data    = r_sh[PAT_W-1];
          w_vld     = 1'b1;
          w_sh      = r_sh << 1;
          w_bit_cnt = r_bit_cnt + BIT_W'(1);
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_W'(1)) begin
          w_load   = 1'b1;
          w_nstate = S_SHIFT;
        end else begin
          w_gap_cnt = r_gap_cnt - GAP_W'(1);
        end
      end
`ifdef SEQ_PARITY_EN
      S_PAR: begin
        w_frame_end = 1'b1;
      end
`endif
      S_DONE: begin
        w_nstate = S_IDLE;
      end
      default: begin
        w_nstate = S_IDLE;
      end
    endcase

    // end of a frame: pick gap, back-to-back reload, or finish
    if (w_frame_end) begin
      if (r_rep_cnt == '0) begin
        w_nstate = S_DONE;
      end else begin
        w_rep_cnt = r_rep_cnt - REP_W'(1);
        if (r_gap != '0) begin
          w_nstate  = S_GAP;
          w_gap_cnt = r_gap;
        end else begin
          w_load   = 1'b1;
          w_nstate = S_SHIFT;
        end
      end
    end

    if (w_load) begin
      w_data    = w_pat[PAT_W-1];
      w_vld     = 1'b1;
      w_sh      = w_pat << 1;
      w_bit_cnt = '0;
    end

    if (abort && (r_state != S_IDLE)) begin
      w_nstate = S_IDLE;
      w_data   = 1'b0;
      w_vld    = 1'b0;
    end
  end

  assign data     = r_data;
  assign data_vld = r_vld;
  assign ready    = (r_state == S_IDLE);
  assign done     = (r_state == S_DONE);
`ifdef SEQ_PARITY_EN
  assign busy     = (r_state == S_SHIFT) || (r_state == S_GAP) || (r_state == S_PAR);
`else
  assign busy     = (r_state == S_SHIFT) || (r_state == S_GAP);
`endif

endmodule

// File: tb/tb_fsm_seq_gen.sv
// Directed self-checking bench for fsm_seq_gen; cycle c is the period after the c-th rising
// edge following the start cycle (cycle 0). Outputs are sampled on the falling edge.
module tb_fsm_seq_gen;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] pat_in;
  logic [3:0] rep_in;
  logic [3:0] gap_in;
  logic       abort;
  logic       data;
  logic       data_vld;
  logic       ready;
  logic       busy;
  logic       done;

  int checks;
  int failures;

  fsm_seq_gen #(.PAT_W(5), .REP_W(4), .GAP_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .pat_in   (pat_in),
    .rep_in   (rep_in),
    .gap_in   (gap_in),
    .abort    (abort),
    .data     (data),
    .data_vld (data_vld),
    .ready    (ready),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // called at a falling edge (cycle 0); start is dropped by the caller in cycle 1
  task automatic launch(input logic [4:0] p, input logic [3:0] r, input logic [3:0] g);
    start  = 1'b1;
    pat_in = p;
    rep_in = r;
    gap_in = g;
  endtask

  task automatic test_reset();
    logic [4:0] got;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    got = {data_vld, data, done, busy, ready};
    checks++;
    if (got !== 5'b00001) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", got, 5'b00001);
    end
    rst_n = 1'b1;
    @(negedge clk);
    got = {data_vld, data, done, busy, ready};
    checks++;
    if (got !== 5'b00001) begin
      failures++;
      $display("FAIL reset_release got=%b exp=%b", got, 5'b00001);
    end
  endtask

  task automatic test_single();
    logic [31:0] ev, ed, edn, eb, er;
    logic [4:0]  got, exp;
    int n;
`ifdef SEQ_PARITY_EN
    n = 8; ev = 32'h7E; ed = 32'h5A; edn = 32'h80; eb = 32'h7E; er = 32'h100;
`else
    n = 7; ev = 32'h3E; ed = 32'h1A; edn = 32'h40; eb = 32'h3E; er = 32'h80;
`endif
    launch(5'b10110, 4'd0, 4'd0);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      got = {data_vld, data, done, busy, ready};
      exp = {ev[c], ed[c], edn[c], eb[c], er[c]};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL single cycle=%0d got=%b exp=%b", c, got, exp);
      end
    end
  endtask

  task automatic test_repeat_gap();
    logic [31:0] ev, ed, edn, eb, er;
    logic [4:0]  got, exp;
    int n;
`ifdef SEQ_PARITY_EN
    n = 16; ev = 32'h7E7E; ed = 32'h6666; edn = 32'h8000; eb = 32'h7FFE; er = 32'h10000;
`else
    n = 14; ev = 32'h1F3E; ed = 32'h1326; edn = 32'h2000; eb = 32'h1FFE; er = 32'h4000;
`endif
    launch(5'b11001, 4'd1, 4'd2);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start  = 1'b0;
        pat_in = 5'b00000;
        rep_in = 4'd7;
        gap_in = 4'd9;
      end
      got = {data_vld, data, done, busy, ready};
      exp = {ev[c], ed[c], edn[c], eb[c], er[c]};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL repeat_gap cycle=%0d got=%b exp=%b", c, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ev, ed, edn, eb, er;
    logic [4:0]  got, exp;
    int n;
`ifdef SEQ_PARITY_EN
    n = 20; ev = 32'h7FFFE; ed = 32'h430C2; edn = 32'h80000; eb = 32'h7FFFE; er = 32'h100000;
`else
    n = 17; ev = 32'hFFFE; ed = 32'h0842; edn = 32'h10000; eb = 32'hFFFE; er = 32'h20000;
`endif
    launch(5'b10000, 4'd2, 4'd0);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      got = {data_vld, data, done, busy, ready};
      exp = {ev[c], ed[c], edn[c], eb[c], er[c]};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL back_to_back cycle=%0d got=%b exp=%b", c, got, exp);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] ev, ed, edn, eb, er;
    logic [4:0]  got, exp;
    int n;
`ifdef SEQ_PARITY_EN
    n = 8; ev = 32'h7E; ed = 32'h5A; edn = 32'h80; eb = 32'h7E; er = 32'h100;
`else
    n = 7; ev = 32'h3E; ed = 32'h1A; edn = 32'h40; eb = 32'h3E; er = 32'h80;
`endif
    launch(5'b10110, 4'd0, 4'd0);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      got = {data_vld, data, done, busy, ready};
      exp = {ev[c], ed[c], edn[c], eb[c], er[c]};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL ignore_start cycle=%0d got=%b exp=%b", c, got, exp);
      end
      if (c == 3) begin
        start  = 1'b1;
        pat_in = 5'b01001;
        rep_in = 4'd3;
      end
      if (c == 4) start = 1'b0;
    end
  endtask

  task automatic test_abort();
    logic [4:0] got, exp;
    launch(5'b11111, 4'd3, 4'd1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      got = {data_vld, data, done, busy, ready};
      exp = (c <= 3) ? 5'b11010 : 5'b00001;
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL abort cycle=%0d got=%b exp=%b", c, got, exp);
      end
      if (c == 3) abort = 1'b1;
      if (c == 4) abort = 1'b0;
    end
    // abort together with start in IDLE: start wins
    launch(5'b10101, 4'd0, 4'd0);
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    got = {data_vld, data, done, busy, ready};
    checks++;
    if (got !== 5'b11010) begin
      failures++;
      $display("FAIL abort_start_idle got=%b exp=%b", got, 5'b11010);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    got = {data_vld, data, done, busy, ready};
    checks++;
    if (got !== 5'b00001) begin
      failures++;
      $display("FAIL abort_cleanup got=%b exp=%b", got, 5'b00001);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [4:0] got, exp;
    launch(5'b10110, 4'd2, 4'd3);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    got = {data_vld, data, done, busy, ready};
    checks++;
    if (got !== 5'b00001) begin
      failures++;
      $display("FAIL reset_mid_frame got=%b exp=%b", got, 5'b00001);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    launch(5'b11001, 4'd0, 4'd0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      exp = {1'b1, (c == 1 || c == 2 || c == 5), 1'b0, 1'b1, 1'b0};
      got = {data_vld, data, done, busy, ready};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL after_reset cycle=%0d got=%b exp=%b", c, got, exp);
      end
    end
    for (int c = 0; c < 4; c++) @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    start    = 1'b0;
    abort    = 1'b0;
    pat_in   = '0;
    rep_in   = '0;
    gap_in   = '0;
    test_reset();
    test_single();
    @(negedge clk);
    test_repeat_gap();
    @(negedge clk);
    test_back_to_back();
    @(negedge clk);
    test_ignore_start();
    @(negedge clk);
    test_abort();
    @(negedge clk);
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fsm_seq_gen.md
Name: fsm_seq_gen

Overview:
- Moore-FSM serial pattern transmitter. It is the source side of the serial bit-stream interface that the sequence-detector FSMs consume.
- Latches a PAT_W-bit pattern on a start handshake and shifts it out MSB-first, one bit per clock.
- Optionally repeats the frame, with a programmable idle gap between repetitions.
- Used as a stimulus/traffic source in front of sequence detectors and as a reusable on-chip pattern emitter.

Parameters:
- PAT_W, 5, pattern width in bits (2..16).
- REP_W, 4, width of the repeat-count field.
- GAP_W, 4, width of the inter-frame gap field.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin a transmission; sampled only when ready=1.
- pat_in  input  PAT_W  pattern to send; latched on acceptance.
- rep_in  input  REP_W  number of frames minus one; latched on acceptance.
- gap_in  input  GAP_W  idle cycles between frames; latched on acceptance.
- abort  input  1  synchronous cancel of an in-progress transmission.
- data  output  1  serial bit, registered.
- data_vld  output  1  high while data carries a pattern bit.
- ready  output  1  high in IDLE only; start is accepted when start&ready.
- busy  output  1  high in SHIFT, GAP or PAR states.
- done  output  1  one-cycle pulse after the final frame completes.

Behaviour:
- Reset (async assert, sync release): state=IDLE, data=0, data_vld=0, busy=0, done=0, ready=1, all counters 0.
- States: IDLE, SHIFT, GAP, PAR (PAR exists only with the optional feature), DONE.
- Outputs are registered or decoded from state only (Moore); no input-to-output combinational path.
- IDLE:
  - data=0, data_vld=0.
  - On start&ready at edge k: latch pat_in, rep_in, gap_in; go to SHIFT.
  - At edge k the MSB of pat_in is loaded into data, so data_vld=1 in cycle k+1.
- SHIFT:
  - Emits bit PAT_W-1 down to 0, one per cycle; bit counter counts 0..PAT_W-1.
  - After bit 0: if frames remain and gap>0, go to GAP. If frames remain and gap=0, reload the shifter and emit the next frame's MSB in the very next cycle (back-to-back). If no frames remain, go to DONE.
- GAP: data=0, data_vld=0, busy=1 for exactly gap cycles, then go to SHIFT with the MSB loaded.
- DONE: done=1 for one cycle, busy=0, ready=0; go to IDLE next cycle.
- Total frames = rep_in+1 (1..2^REP_W).
- Total busy cycles = PAT_W*(rep_in+1) + gap_in*rep_in (no parity).
- The latched pattern, repeat count and gap are stable for the whole transmission; input changes after acceptance have no effect.
- start while ready=0 is ignored; it is not queued.
- abort:
  - In any non-IDLE state, abort forces IDLE on the next edge with data=0, data_vld=0, and no done pulse.
  - abort has priority over all transitions.
  - abort in IDLE has no effect. abort and start together in IDLE: start wins.
- Counters do not wrap: the repeat counter decrements to 0, and the gap counter reloads from the latched value for each gap.
- Reset mid-transmission: immediate return to reset values, no done pulse.

Optional Feature:
- Macro: SEQ_PARITY_EN.
- Defined: after bit 0 of every frame, the FSM enters PAR for one cycle with data = even parity (XOR of the pattern bits) and data_vld=1, then continues with GAP, the next frame or DONE exactly as above. The busy cycle count grows by rep_in+1.
- Undefined: the PAR state and its logic are not built; frames are PAT_W bits.

Test Plan:
- Single frame: pat_in=5'b10110, rep_in=0, gap_in=0, start pulse at cycle 0 -> data_vld=1 on cycles 1-5 with data=1,0,1,1,0; done=1 on cycle 6; ready=1 from cycle 7.
- Repeat with gap: pat_in=5'b11001, rep_in=1, gap_in=2 -> bits 1,1,0,0,1 on cycles 1-5; data=0 and data_vld=0 on cycles 6-7; bits 1,1,0,0,1 on cycles 8-12; done on cycle 13.
- Back-to-back: pat_in=5'b10000, rep_in=2, gap_in=0 -> 15 contiguous data_vld cycles with 1 on cycles 1, 6 and 11; done on cycle 16.
- Ignore and abort: start pulsed again at cycle 3 with a different pat_in -> no effect. abort at cycle 3 -> cycle 4 has data_vld=0 and ready=1; done never asserts.
- Reset mid-frame: assert rst_n=0 during cycle 3 -> outputs at reset values immediately; after release, a new start transmits correctly from the MSB.
- SEQ_PARITY_EN defined: pat_in=5'b10110, rep_in=0 -> bits 1,0,1,1,0 on cycles 1-5, then parity bit 1 on cycle 6 with data_vld=1; done on cycle 7.
